// File: rtl/id_ex_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_reg
// Description : ID/EX pipeline register with stall (hold), flush (bubble) and
//               a saturating count of bubbles that displaced a real instruction.
// Revision    : 1.0  initial release
// ============================================================================
module id_ex_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  id_valid_i,
    input  logic [DATA_WIDTH-1:0] id_pc_i,
    input  logic [DATA_WIDTH-1:0] id_rs1_data_i,
    input  logic [DATA_WIDTH-1:0] id_rs2_data_i,
    input  logic [DATA_WIDTH-1:0] id_imm_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rd_addr_i,
    input  logic [ALU_OP_W-1:0]   id_alu_op_i,
    input  logic                  id_alu_src_b_i,
    input  logic                  id_mem_read_i,
    input  logic                  id_mem_write_i,
    input  logic                  id_reg_write_i,
    input  logic [1:0]            id_wb_sel_i,
    input  logic                  id_branch_i,
    input  logic                  id_jump_i,
    output logic                  ex_valid_o,
    output logic [DATA_WIDTH-1:0] ex_pc_o,
    output logic [DATA_WIDTH-1:0] ex_rs1_data_o,
    output logic [DATA_WIDTH-1:0] ex_rs2_data_o,
    output logic [DATA_WIDTH-1:0] ex_imm_o,
    output logic [REG_ADDR_W-1:0] ex_rs1_addr_o,
    output logic [REG_ADDR_W-1:0] ex_rs2_addr_o,
    output logic [REG_ADDR_W-1:0] ex_rd_addr_o,
    output logic [ALU_OP_W-1:0]   ex_alu_op_o,
    output logic                  ex_alu_src_b_o,
    output logic                  ex_mem_read_o,
    output logic                  ex_mem_write_o,
    output logic                  ex_reg_write_o,
    output logic [1:0]            ex_wb_sel_o,
    output logic                  ex_branch_o,
    output logic                  ex_jump_o,
    output logic [15:0]           bubble_cnt_o
);

    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    logic                  valid_d,     valid_q;
    logic [DATA_WIDTH-1:0] pc_d,        pc_q;
    logic [DATA_WIDTH-1:0] rs1_data_d,  rs1_data_q;
    logic [DATA_WIDTH-1:0] rs2_data_d,  rs2_data_q;
    logic [DATA_WIDTH-1:0] imm_d,       imm_q;
    logic [REG_ADDR_W-1:0] rs1_addr_d,  rs1_addr_q;
    logic [REG_ADDR_W-1:0] rs2_addr_d,  rs2_addr_q;
    logic [REG_ADDR_W-1:0] rd_addr_d,   rd_addr_q;
    logic [ALU_OP_W-1:0]   alu_op_d,    alu_op_q;
    logic                  alu_src_b_d, alu_src_b_q;
    logic                  mem_read_d,  mem_read_q;
    logic                  mem_write_d, mem_write_q;
    logic                  reg_write_d, reg_write_q;
    logic [1:0]            wb_sel_d,    wb_sel_q;
    logic                  branch_d,    branch_q;
    logic                  jump_d,      jump_q;
    logic [15:0]           bubble_cnt_d, bubble_cnt_q;

    always_comb begin
        valid_d      = valid_q;
        pc_d         = pc_q;
        rs1_data_d   = rs1_data_q;
        rs2_data_d   = rs2_data_q;
        imm_d        = imm_q;
        rs1_addr_d   = rs1_addr_q;
        rs2_addr_d   = rs2_addr_q;
        rd_addr_d    = rd_addr_q;
        alu_op_d     = alu_op_q;
        alu_src_b_d  = alu_src_b_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        reg_write_d  = reg_write_q;
        wb_sel_d     = wb_sel_q;
        branch_d     = branch_q;
        jump_d       = jump_q;
        bubble_cnt_d = bubble_cnt_q;

        if (flush_i) begin
            // Bubble counts only when it displaces a real instruction.
            if ((valid_q || id_valid_i) && (bubble_cnt_q != C_CNT_MAX)) begin
                bubble_cnt_d = bubble_cnt_q + 16'd1;
            end
            valid_d     = 1'b0;
            pc_d        = '0;
            rs1_data_d  = '0;
            rs2_data_d  = '0;
            imm_d       = '0;
            rs1_addr_d  = '0;
            rs2_addr_d  = '0;
            rd_addr_d   = '0;
            alu_op_d    = '0;
            alu_src_b_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            reg_write_d = 1'b0;
            wb_sel_d    = '0;
            branch_d    = 1'b0;
            jump_d      = 1'b0;
        end else if (!stall_i) begin
            valid_d     = id_valid_i;
            pc_d        = id_pc_i;
            rs1_data_d  = id_rs1_data_i;
            rs2_data_d  = id_rs2_data_i;
            imm_d       = id_imm_i;
            rs1_addr_d  = id_rs1_addr_i;
            rs2_addr_d  = id_rs2_addr_i;
            rd_addr_d   = id_rd_addr_i;
            alu_op_d    = id_alu_op_i;
            alu_src_b_d = id_alu_src_b_i;
            wb_sel_d    = id_wb_sel_i;
            // An invalid slot must never commit architectural side effects.
            mem_read_d  = id_mem_read_i  & id_valid_i;
            mem_write_d = id_mem_write_i & id_valid_i;
            reg_write_d = id_reg_write_i & id_valid_i;
            branch_d    = id_branch_i    & id_valid_i;
            jump_d      = id_jump_i      & id_valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            rs1_addr_q   <= '0;
            rs2_addr_q   <= '0;
            rd_addr_q    <= '0;
            alu_op_q     <= '0;
            alu_src_b_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            wb_sel_q     <= '0;
            branch_q     <= 1'b0;
            jump_q       <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            rs1_data_q   <= rs1_data_d;
            rs2_data_q   <= rs2_data_d;
            imm_q        <= imm_d;
            rs1_addr_q   <= rs1_addr_d;
            rs2_addr_q   <= rs2_addr_d;
            rd_addr_q    <= rd_addr_d;
            alu_op_q     <= alu_op_d;
            alu_src_b_q  <= alu_src_b_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            reg_write_q  <= reg_write_d;
            wb_sel_q     <= wb_sel_d;
            branch_q     <= branch_d;
            jump_q       <= jump_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_valid_o     = valid_q;
    assign ex_pc_o        = pc_q;
    assign ex_rs1_data_o  = rs1_data_q;
    assign ex_rs2_data_o  = rs2_data_q;
    assign ex_imm_o       = imm_q;
    assign ex_rs1_addr_o  = rs1_addr_q;
    assign ex_rs2_addr_o  = rs2_addr_q;
    assign ex_rd_addr_o   = rd_addr_q;
    assign ex_alu_op_o    = alu_op_q;
    assign ex_alu_src_b_o = alu_src_b_q;
    assign ex_mem_read_o  = mem_read_q;
    assign ex_mem_write_o = mem_write_q;
    assign ex_reg_write_o = reg_write_q;
    assign ex_wb_sel_o    = wb_sel_q;
    assign ex_branch_o    = branch_q;
    assign ex_jump_o      = jump_q;
    assign bubble_cnt_o   = bubble_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_reg
// Description : Directed plus randomized checks of id_ex_reg against a
//               slot-level reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_id_ex_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [3:0]  alu_op;
        logic        alu_src_b;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic [1:0]  wb_sel;
        logic        branch;
        logic        jump;
    } slot_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    slot_t       id_s = '0;
    slot_t       ex_s;
    logic [15:0] cnt;

    slot_t       m_slot = '0;
    logic [15:0] m_cnt  = '0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_ex_reg dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .stall_i        (stall),
        .flush_i        (flush),
        .id_valid_i     (id_s.valid),
        .id_pc_i        (id_s.pc),
        .id_rs1_data_i  (id_s.rs1_data),
        .id_rs2_data_i  (id_s.rs2_data),
        .id_imm_i       (id_s.imm),
        .id_rs1_addr_i  (id_s.rs1_addr),
        .id_rs2_addr_i  (id_s.rs2_addr),
        .id_rd_addr_i   (id_s.rd_addr),
        .id_alu_op_i    (id_s.alu_op),
        .id_alu_src_b_i (id_s.alu_src_b),
        .id_mem_read_i  (id_s.mem_read),
        .id_mem_write_i (id_s.mem_write),
        .id_reg_write_i (id_s.reg_write),
        .id_wb_sel_i    (id_s.wb_sel),
        .id_branch_i    (id_s.branch),
        .id_jump_i      (id_s.jump),
        .ex_valid_o     (ex_s.valid),
        .ex_pc_o        (ex_s.pc),
        .ex_rs1_data_o  (ex_s.rs1_data),
        .ex_rs2_data_o  (ex_s.rs2_data),
        .ex_imm_o       (ex_s.imm),
        .ex_rs1_addr_o  (ex_s.rs1_addr),
        .ex_rs2_addr_o  (ex_s.rs2_addr),
        .ex_rd_addr_o   (ex_s.rd_addr),
        .ex_alu_op_o    (ex_s.alu_op),
        .ex_alu_src_b_o (ex_s.alu_src_b),
        .ex_mem_read_o  (ex_s.mem_read),
        .ex_mem_write_o (ex_s.mem_write),
        .ex_reg_write_o (ex_s.reg_write),
        .ex_wb_sel_o    (ex_s.wb_sel),
        .ex_branch_o    (ex_s.branch),
        .ex_jump_o      (ex_s.jump),
        .bubble_cnt_o   (cnt)
    );

    // Reference: a stage slot that is cleared, replaced by a bubble, kept, or
    // refilled with the decode slot (side effects dropped when the slot is empty).
    task automatic model_edge();
        if (rst) begin
            m_slot = '0;
            m_cnt  = 16'd0;
        end else if (flush) begin
            if ((m_slot.valid || id_s.valid) && m_cnt < 16'hFFFF) m_cnt = m_cnt + 16'd1;
            m_slot = '0;
        end else if (!stall) begin
            m_slot = id_s;
            if (!id_s.valid) begin
                m_slot.mem_read  = 1'b0;
                m_slot.mem_write = 1'b0;
                m_slot.reg_write = 1'b0;
                m_slot.branch    = 1'b0;
                m_slot.jump      = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_slot"}, 256'(ex_s), 256'(m_slot));
        check({tag, "_cnt"},  256'(cnt),  256'(m_cnt));
    endtask

    task automatic rand_inputs();
        id_s.valid     = ($urandom_range(3) != 0);
        id_s.pc        = $urandom;
        id_s.rs1_data  = $urandom;
        id_s.rs2_data  = $urandom;
        id_s.imm       = $urandom;
        id_s.rs1_addr  = 5'($urandom);
        id_s.rs2_addr  = 5'($urandom);
        id_s.rd_addr   = 5'($urandom);
        id_s.alu_op    = 4'($urandom);
        id_s.alu_src_b = 1'($urandom);
        id_s.mem_read  = 1'($urandom);
        id_s.mem_write = 1'($urandom);
        id_s.reg_write = 1'($urandom);
        id_s.wb_sel    = 2'($urandom);
        id_s.branch    = 1'($urandom);
        id_s.jump      = 1'($urandom);
    endtask

    initial begin
        // Reset with every input driven nonzero
        rst = 1'b1; stall = 1'b1; flush = 1'b1;
        id_s = '1;
        step();
        check("reset_slot", 256'(ex_s), 256'(0));
        check("reset_cnt",  256'(cnt),  256'(0));

        // Single load, one-cycle latency
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        id_s = '0;
        id_s.valid = 1'b1; id_s.imm = 32'h1111_1111; id_s.pc = 32'h0000_0040;
        id_s.rd_addr = 5'd7; id_s.reg_write = 1'b1;
        step();
        check("load_imm", 256'(ex_s.imm), 256'(32'h1111_1111));
        check("load_pc",  256'(ex_s.pc),  256'(32'h0000_0040));
        check("load_rd",  256'(ex_s.rd_addr), 256'(5'd7));
        check("load_rw",  256'(ex_s.reg_write), 256'(1'b1));
        check_all("load");

        // Stall holds while the decode slot changes
        stall = 1'b1; id_s.imm = 32'h2222_2222; id_s.pc = 32'h0000_0044;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_imm", 256'(ex_s.imm), 256'(32'h1111_1111));
        end
        stall = 1'b0;
        step();
        check("release_imm", 256'(ex_s.imm), 256'(32'h2222_2222));

        // Flush beats stall
        flush = 1'b1; stall = 1'b1;
        step();
        check("flush_valid", 256'(ex_s.valid), 256'(0));
        check("flush_rw",    256'(ex_s.reg_write), 256'(0));
        check("flush_rd",    256'(ex_s.rd_addr), 256'(0));
        check("flush_cnt",   256'(cnt), 256'(1));

        // Flush of an empty stage with an empty decode slot adds no bubble
        id_s.valid = 1'b0;
        step();
        check("empty_flush_cnt", 256'(cnt), 256'(1));

        // Invalid slot drops side effects but copies data
        flush = 1'b0; stall = 1'b0;
        id_s.mem_write = 1'b1; id_s.reg_write = 1'b1; id_s.rs1_data = 32'hDEAD_BEEF;
        step();
        check("inv_mw",   256'(ex_s.mem_write), 256'(0));
        check("inv_rw",   256'(ex_s.reg_write), 256'(0));
        check("inv_data", 256'(ex_s.rs1_data), 256'(32'hDEAD_BEEF));

        // Randomized mix of load / stall / flush / reset
        for (int i = 0; i < 500; i++) begin
            rand_inputs();
            rst   = ($urandom_range(39) == 0);
            flush = ($urandom_range(6) == 0);
            stall = ($urandom_range(3) == 0);
            step();
            check_all("rand");
        end

        // Saturation of the bubble counter
        rst = 1'b1; flush = 1'b0; stall = 1'b0;
        step();
        rst = 1'b0; flush = 1'b1; id_s.valid = 1'b1;
        for (int i = 0; i < 65535; i++) step();
        check("sat_reach", 256'(cnt), 256'(16'hFFFF));
        step();
        check("sat_hold", 256'(cnt), 256'(16'hFFFF));
        check_all("sat");

        // Reset during flush and stall wins
        rst = 1'b1; stall = 1'b1; id_s = '1;
        step();
        check("rst_mid_flush_slot", 256'(ex_s), 256'(0));
        check("rst_mid_flush_cnt",  256'(cnt),  256'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
